coprocessor_command_decoder: RTL and testbench

Translates ASCII command bytes from the UART receiver into 2-bit operation codes for the coprocessor. Sits between the UART RX block (`byte_received`, `rx_data_ready`) and the coprocessor control FSM. It issues a one-cycle command pulse per accepted byte and ignores traffic while the coprocessor reports busy.

---
 rtl/coproc_cmd_pkg.sv | 43 ++++
 rtl/coprocessor_command_decoder.sv | 54 +++++
 tb/tb_coprocessor_command_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/coproc_cmd_pkg.sv
// Shared command-byte definitions for the coprocessor command path.
// Holds the ASCII byte values, opcode and FSM enums, and the byte-to-opcode decoder.
package coproc_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 2;

  localparam logic [BYTE_W-1:0] CMD_BYTE_1 = 8'h31;
  localparam logic [BYTE_W-1:0] CMD_BYTE_2 = 8'h32;
  localparam logic [BYTE_W-1:0] CMD_BYTE_3 = 8'h33;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE = 2'b00,
    CMD_OP1  = 2'b01,
    CMD_OP2  = 2'b10,
    CMD_OP3  = 2'b11
  } cmd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    cmd_t cmd;
  } ascii_cmd_t;

  // Maps an ASCII byte to an opcode; anything outside '1'..'3' is flagged invalid.
  function automatic ascii_cmd_t ascii_to_cmd(input logic [BYTE_W-1:0] b);
    ascii_cmd_t r;
    r.valid = 1'b1;
    r.cmd   = CMD_NONE;
    case (b)
      CMD_BYTE_1: r.cmd = CMD_OP1;
      CMD_BYTE_2: r.cmd = CMD_OP2;
      CMD_BYTE_3: r.cmd = CMD_OP3;
      default:    r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/coprocessor_command_decoder.sv
// Turns UART RX command bytes into one-cycle opcode pulses for the coprocessor,
// dropping invalid bytes and anything that arrives while the coprocessor is busy.
module coprocessor_command_decoder
  import coproc_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_received,
  input  logic              rx_data_ready,
  input  logic              coprocessor_busy,
  output logic [CMD_W-1:0]  command
);

  logic       rx_q;
  state_t     state_q, state_d;
  cmd_t       command_q, command_d;
  ascii_cmd_t decoded;
  logic       accept;

  assign decoded = ascii_to_cmd(byte_received);

  // A held strobe counts once: only the low-to-high transition is a new byte.
  assign accept = rx_data_ready & ~rx_q & ~coprocessor_busy & decoded.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q      <= 1'b0;
      state_q   <= ST_IDLE;
      command_q <= CMD_NONE;
    end else begin
      rx_q      <= rx_data_ready;
      state_q   <= state_d;
      command_q <= command_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes landing during ISSUE are ignored; the pulse always ends after one cycle.
  always_comb begin
    command_d = CMD_NONE;
    if (state_q == ST_IDLE && accept) command_d = decoded.cmd;
  end

  assign command = CMD_W'(command_q);

endmodule

// File: tb/tb_coprocessor_command_decoder.sv
// Directed bench for coprocessor_command_decoder: inputs change on the falling
// edge, outputs are checked on the following falling edge.
module tb_coprocessor_command_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] byte_received;
  logic       rx_data_ready;
  logic       coprocessor_busy;
  logic [1:0] command;

  int checks;
  int failures;

  coprocessor_command_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .byte_received    (byte_received),
    .rx_data_ready    (rx_data_ready),
    .coprocessor_busy (coprocessor_busy),
    .command          (command)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; checks the cycle after the sampling edge and the one after that.
  task automatic pulse(input string tag, input logic [7:0] b, input logic [1:0] exp);
    byte_received = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    chk({tag, "_pulse"}, command, exp);
    @(negedge clk);
    chk({tag, "_after"}, command, 2'b00);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    byte_received    = 8'h00;
    rx_data_ready    = 1'b0;
    coprocessor_busy = 1'b0;
    #1 rst = 1'b0;

    // Reset held: toggling inputs must not move the output.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      byte_received    = 8'h31 + 8'(i % 3);
      rx_data_ready    = ~rx_data_ready;
      coprocessor_busy = (i == 2);
      chk("reset_hold", command, 2'b00);
    end
    @(negedge clk);
    rx_data_ready    = 1'b0;
    coprocessor_busy = 1'b0;
    rst              = 1'b1;
    @(negedge clk);
    chk("reset_release", command, 2'b00);
    @(negedge clk);
    chk("reset_release2", command, 2'b00);

    // Valid bytes while idle.
    pulse("byte_32", 8'h32, 2'b10);
    pulse("byte_31", 8'h31, 2'b01);
    pulse("byte_33", 8'h33, 2'b11);

    // Invalid bytes are discarded.
    pulse("byte_72", 8'h72, 2'b00);
    pulse("byte_61", 8'h61, 2'b00);
    pulse("byte_0a", 8'h0A, 2'b00);
    pulse("byte_35", 8'h35, 2'b00);
    pulse("byte_30", 8'h30, 2'b00);
    pulse("byte_after_invalid", 8'h31, 2'b01);

    // Busy gating, no replay after busy falls.
    coprocessor_busy = 1'b1;
    pulse("busy_32", 8'h32, 2'b00);
    pulse("busy_31", 8'h31, 2'b00);
    coprocessor_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("no_replay", command, 2'b00);
    end
    pulse("unbusy_32", 8'h32, 2'b10);

    // Busy rising on the strobe's own sampling edge blocks it.
    coprocessor_busy = 1'b1;
    pulse("busy_same_edge", 8'h33, 2'b00);
    coprocessor_busy = 1'b0;
    pulse("busy_fall_admits", 8'h33, 2'b11);

    // Long strobe gives exactly one pulse; re-raise gives another.
    byte_received = 8'h31;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("long_strobe", command, (i == 0) ? 2'b01 : 2'b00);
    end
    rx_data_ready = 1'b0;
    @(negedge clk);
    chk("long_strobe_low", command, 2'b00);
    pulse("long_strobe_again", 8'h31, 2'b01);

    // Async reset half a cycle into an active pulse.
    byte_received = 8'h33;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
    chk("pre_async_reset", command, 2'b11);
    #3 rst = 1'b0;
    #1;
    chk("async_reset_drop", command, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_async_reset", command, 2'b00);
    end

    // Strobe already high at reset release counts as a rising transition.
    rst           = 1'b0;
    byte_received = 8'h32;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    chk("high_at_release", command, 2'b10);
    @(negedge clk);
    chk("high_at_release_end", command, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
